// File: rtl/nibble_add_driver.sv
// nibble_add_driver: self-checking operand transmitter for the 4-bit nibble adder.
// Drives packed {a,b} operand bytes, samples the adder's sum LATENCY cycles
// later and accumulates a saturating mismatch count plus the last failing byte.
// Optional build macro: ADD_DRIVER_EXHAUSTIVE_EN replaces the LFSR with an
// 8-bit up-counter from 8'h00 and runs all 256 operand pairs.
//
// Handshake: start is a single-cycle request honoured only in IDLE or DONE
// (never while busy); operands are registered and change only on the edge
// that enters DRIVE; sum_in is sampled in CHECK, LATENCY cycles after that.
// dbg_state encoding: 0 IDLE, 1 DRIVE, 2 WAIT, 3 CHECK, 4 DONE.
module nibble_add_driver #(
  parameter int         LATENCY     = 1,
  parameter int         NUM_VECTORS = 16,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] sum_in,
  output logic [7:0] operands,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] last_fail,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

`ifdef ADD_DRIVER_EXHAUSTIVE_EN
  localparam int              VW        = 9;
  localparam logic [VW-1:0]   VEC_TOTAL = 9'd256;
  localparam logic [7:0]      GEN_INIT  = 8'h00;
`else
  localparam int              VW        = 8;
  localparam logic [VW-1:0]   VEC_TOTAL = 8'(NUM_VECTORS);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [7:0]      GEN_INIT  = (SEED == 8'h00) ? 8'h01 : SEED;
`endif

  // WAIT covers LATENCY-1 cycles; the counter is loaded with LATENCY-2 in DRIVE.
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_gen;
  logic [7:0]    r_operands;
  logic [3:0]    r_err_count;
  logic [7:0]    r_last_fail;
  logic [VW-1:0] r_vec_cnt;
  logic [3:0]    r_wait_cnt;

  logic [7:0]    w_gen_next;
  logic [3:0]    w_ref;
  logic          w_mismatch;
  logic [VW-1:0] w_vec_next;
  logic          w_last_vec;
  logic          w_start_ok;

`ifdef ADD_DRIVER_EXHAUSTIVE_EN
  assign w_gen_next = r_gen + 8'd1;
`else
  // Fibonacci LFSR, shift left, taps 7,5,4,3 feed the new LSB.
  assign w_gen_next = {r_gen[6:0], r_gen[7] ^ r_gen[5] ^ r_gen[4] ^ r_gen[3]};
`endif

  // 4-bit add drops the carry, i.e. (a+b) mod 16.
  assign w_ref      = r_operands[7:4] + r_operands[3:0];
  assign w_mismatch = (sum_in != w_ref);
  assign w_vec_next = r_vec_cnt + 1'b1;
  assign w_last_vec = (w_vec_next == VEC_TOTAL);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic for the drive/wait/check sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_DRIVE;
      S_DRIVE: w_next_state = (LATENCY > 1) ? S_WAIT : S_CHECK;
      S_WAIT:  if (r_wait_cnt == 4'd0) w_next_state = S_CHECK;
      S_CHECK: w_next_state = w_last_vec ? S_DONE : S_DRIVE;
      S_DONE:  if (start) w_next_state = S_DRIVE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: run initialisation, wait countdown, result check and vector advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gen       <= 8'h00;
      r_operands  <= 8'h00;
      r_err_count <= 4'd0;
      r_last_fail <= 8'h00;
      r_vec_cnt   <= '0;
      r_wait_cnt  <= 4'd0;
    end else if (w_start_ok) begin
      r_gen       <= GEN_INIT;
      r_operands  <= GEN_INIT;
      r_err_count <= 4'd0;
      r_last_fail <= 8'h00;
      r_vec_cnt   <= '0;
    end else begin
      case (r_state)
        S_DRIVE: r_wait_cnt <= WAIT_LOAD;
        S_WAIT:  r_wait_cnt <= r_wait_cnt - 4'd1;
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != 4'hF) r_err_count <= r_err_count + 4'd1;
            r_last_fail <= r_operands;
          end
          r_vec_cnt <= w_vec_next;
          if (!w_last_vec) begin
            r_gen      <= w_gen_next;
            r_operands <= w_gen_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign operands  = r_operands;
  assign busy      = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_err_count == 4'd0);
  assign err_count = r_err_count;
  assign last_fail = r_last_fail;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nibble_add_driver.sv
// Bench for nibble_add_driver: two instances (LATENCY=1 and LATENCY=3) each
// looped through a behavioural adder whose per-operand fault table adds 1.
module tb_nibble_add_driver;

`ifdef ADD_DRIVER_EXHAUSTIVE_EN
  localparam int         NV        = 256;
  localparam logic [7:0] GEN_START = 8'h00;
`else
  localparam int         NV        = 16;
  localparam logic [7:0] GEN_START = 8'hA5;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       start1, start3;
  logic [3:0] sum1, sum3;
  logic [7:0] ops1, ops3, lf1, lf3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [3:0] err1, err3;
  logic [2:0] st1, st3;

  nibble_add_driver #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .sum_in(sum1),
    .operands(ops1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .last_fail(lf1), .dbg_state(st1)
  );

  nibble_add_driver #(.LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .sum_in(sum3),
    .operands(ops3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .last_fail(lf3), .dbg_state(st3)
  );

  // adder models: registered, (a+b+fault) mod 16, depth 1 and 3
  bit bad_tab[256];
  logic [3:0] p3a, p3b;
  always @(posedge clk) sum1 <= 4'(ops1[7:4] + ops1[3:0] + 4'(bad_tab[ops1]));
  always @(posedge clk) begin
    p3a  <= 4'(ops3[7:4] + ops3[3:0] + 4'(bad_tab[ops3]));
    p3b  <= p3a;
    sum3 <= p3b;
  end

  // selected instance view
  logic       sel;
  logic [7:0] m_ops, m_lf;
  logic       m_busy, m_done, m_pass;
  logic [3:0] m_err;
  logic [2:0] m_st;
  assign m_ops  = sel ? ops3  : ops1;
  assign m_lf   = sel ? lf3   : lf1;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_pass = sel ? pass3 : pass1;
  assign m_err  = sel ? err3  : err1;
  assign m_st   = sel ? st3   : st1;

  int total = 0;
  int bad   = 0;
  logic [7:0] g_final_ops;
  int         g_err;
  logic [7:0] g_last;

  function automatic logic [7:0] next_vec(input logic [7:0] v);
    int x, fb;
    x = int'(v);
`ifdef ADD_DRIVER_EXHAUSTIVE_EN
    return 8'((x + 1) % 256);
`else
    fb = ((x / 128) + (x / 32) + (x / 16) + (x / 8)) % 2;
    return 8'(((x * 2) % 256) + fb);
`endif
  endfunction

  // driver tasks
  task automatic drive_start(input logic v);
    if (sel) start3 = v;
    else     start1 = v;
  endtask

  task automatic set_faults(input int mode);  // 0 ideal, 1 all faulty, 2 random
    for (int i = 0; i < 256; i++)
      bad_tab[i] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
  endtask

  // one full run with scoreboard; mid>0 pulses start during cycle mid
  task automatic run_vectors(input int mid);
    logic [7:0] exp_q[$];
    logic [7:0] v, want;
    int per, span, exp_err, a, b, ideal, got;
    logic [7:0] exp_last;
    per = (sel ? 3 : 1) + 1;
    span = NV * per;
    v = GEN_START;
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(v);
      v = next_vec(v);
    end
    exp_err = 0;
    exp_last = 8'h00;
    foreach (exp_q[i]) begin
      a = int'(exp_q[i]) / 16;
      b = int'(exp_q[i]) % 16;
      ideal = (a + b) % 16;
      got = (a + b + int'(bad_tab[exp_q[i]])) % 16;
      if (got != ideal) begin
        exp_err = (exp_err < 15) ? exp_err + 1 : 15;
        exp_last = exp_q[i];
      end
    end
    g_final_ops = exp_q[NV-1];
    g_err = exp_err;
    g_last = exp_last;

    @(negedge clk);
    drive_start(1'b1);
    for (int c = 1; c <= span + 1; c++) begin
      @(negedge clk);
      drive_start(1'b0);
      if (c <= span) begin
        total++;
        if ({m_busy, m_done} !== 2'b10) begin
          bad++;
          $display("FAIL run_busy_done c=%0d: got %b want 10", c, {m_busy, m_done});
        end
        if ((c - 1) % per == 0) begin
          want = exp_q.pop_front();
          total++;
          if (m_ops !== want) begin
            bad++;
            $display("FAIL run_operands c=%0d: got %h want %h", c, m_ops, want);
          end
        end
        if (c == 1) begin
          total++;
          if (m_err !== 4'd0 || m_lf !== 8'h00) begin
            bad++;
            $display("FAIL run_clear: err got %0d want 0, last_fail got %h want 00", m_err, m_lf);
          end
        end
        if (c == mid) drive_start(1'b1);
      end else begin
        total++;
        if ({m_busy, m_done} !== 2'b01) begin
          bad++;
          $display("FAIL run_done_timing: got %b want 01", {m_busy, m_done});
        end
        total++;
        if (m_err !== 4'(exp_err)) begin
          bad++;
          $display("FAIL run_err_count: got %0d want %0d", m_err, exp_err);
        end
        total++;
        if (m_lf !== exp_last) begin
          bad++;
          $display("FAIL run_last_fail: got %h want %h", m_lf, exp_last);
        end
        total++;
        if (m_pass !== (exp_err == 0)) begin
          bad++;
          $display("FAIL run_pass: got %b want %b", m_pass, (exp_err == 0));
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start1 = 1'b1;
    start3 = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ops1, busy1, done1, pass1, err1, lf1, st1} !== 30'd0 ||
        {ops3, busy3, done3, pass3, err3, lf3, st3} !== 30'd0) begin
      bad++;
      $display("FAIL reset_values: got %h / %h want 0",
               {ops1, busy1, done1, pass1, err1, lf1, st1},
               {ops3, busy3, done3, pass3, err3, lf3, st3});
    end
    reset = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({ops1, busy1, done1, pass1, err1, lf1, st1} !== 30'd0) begin
        bad++;
        $display("FAIL reset_idle_hold: got %h want 0", {ops1, busy1, done1, pass1, err1, lf1, st1});
      end
    end
  endtask

  task automatic test_ideal;
    sel = 1'b0;
    set_faults(0);
    run_vectors(-1);
  endtask

  task automatic test_done_hold;
    repeat ($urandom_range(5, 1)) @(negedge clk);
    total++;
    if (m_done !== 1'b1 || m_ops !== g_final_ops || m_err !== 4'(g_err) || m_lf !== g_last) begin
      bad++;
      $display("FAIL done_hold: done=%b ops=%h err=%0d lf=%h want 1 %h %0d %h",
               m_done, m_ops, m_err, m_lf, g_final_ops, g_err, g_last);
    end
  endtask

  task automatic test_faulty;
    sel = 1'b0;
    set_faults(1);
    run_vectors(-1);
  endtask

  task automatic test_random_midstart;
    sel = 1'b0;
    set_faults(2);
    run_vectors($urandom_range(NV * 2 - 1, 2));
  endtask

  task automatic test_restart_from_done;
    sel = 1'b0;
    set_faults(0);
    run_vectors($urandom_range(NV * 2 - 1, 2));
  endtask

  task automatic test_reset_in_wait;
    sel = 1'b1;
    set_faults(2);
    @(negedge clk);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    @(negedge clk);
    total++;
    if (st3 !== 3'd2 || busy3 !== 1'b1) begin
      bad++;
      $display("FAIL wait_state: state got %0d want 2, busy got %b want 1", st3, busy3);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({ops3, busy3, done3, pass3, err3, lf3, st3} !== 30'd0) begin
      bad++;
      $display("FAIL reset_in_wait: got %h want 0", {ops3, busy3, done3, pass3, err3, lf3, st3});
    end
    reset = 1'b0;
    run_vectors(-1);
  endtask

  initial begin
    reset = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    sel = 1'b0;
    set_faults(0);
    test_reset();
    test_ideal();
    test_done_hold();
    test_faulty();
    test_done_hold();
    test_random_midstart();
    test_restart_from_done();
    test_reset_in_wait();
    test_done_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
